// File: rtl/axi4_read_arbiter_pkg.sv
// Shared definitions for the AXI4 read arbiter slice.
// Contents:
//   state_t          arbiter FSM states (idle / address phase / data phase)
//   AXI_BURST_INCR   ARBURST encoding driven on every request
//   AXI_RESP_*       RRESP encodings (the arbiter passes RRESP through untouched)
package axi4_read_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4_read_arbiter_if.sv
// Bus bundle for the AXI4 read arbiter: the NUM_PORTS requester-side AR/R
// channels (flattened, port p uses slice [p*W +: W]) plus the single shared
// AR/R master port toward the interconnect or memory.
// Modports:
//   master  the arbiter itself: consumes requester AR/RREADY and master R,
//           drives requester ARREADY/R and the master AR/RREADY
//   slave   the surroundings (requesters + downstream memory), mirrored
interface axi4_read_arbiter_if #(
  parameter int NUM_PORTS      = 2,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_DATA_WIDTH = 32
);

  logic [NUM_PORTS*AXI_ID_WIDTH-1:0]   s_arid;
  logic [NUM_PORTS*AXI_ADDR_WIDTH-1:0] s_araddr;
  logic [NUM_PORTS*AXI_LEN_WIDTH-1:0]  s_arlen;
  logic [NUM_PORTS-1:0]                s_arvalid;
  logic [NUM_PORTS-1:0]                s_arready;
  logic [NUM_PORTS*AXI_ID_WIDTH-1:0]   s_rid;
  logic [NUM_PORTS*AXI_DATA_WIDTH-1:0] s_rdata;
  logic [NUM_PORTS*2-1:0]              s_rresp;
  logic [NUM_PORTS-1:0]                s_rlast;
  logic [NUM_PORTS-1:0]                s_rvalid;
  logic [NUM_PORTS-1:0]                s_rready;

  logic [AXI_ID_WIDTH-1:0]   m_axi4_arid;
  logic [AXI_ADDR_WIDTH-1:0] m_axi4_araddr;
  logic [AXI_LEN_WIDTH-1:0]  m_axi4_arlen;
  logic [2:0]                m_axi4_arsize;
  logic [1:0]                m_axi4_arburst;
  logic                      m_axi4_arvalid;
  logic                      m_axi4_arready;
  logic [AXI_ID_WIDTH-1:0]   m_axi4_rid;
  logic [AXI_DATA_WIDTH-1:0] m_axi4_rdata;
  logic [1:0]                m_axi4_rresp;
  logic                      m_axi4_rlast;
  logic                      m_axi4_rvalid;
  logic                      m_axi4_rready;

  modport master (
    input  s_arid, s_araddr, s_arlen, s_arvalid, s_rready,
    input  m_axi4_arready, m_axi4_rid, m_axi4_rdata, m_axi4_rresp,
    input  m_axi4_rlast, m_axi4_rvalid,
    output s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
    output m_axi4_arid, m_axi4_araddr, m_axi4_arlen, m_axi4_arsize,
    output m_axi4_arburst, m_axi4_arvalid, m_axi4_rready
  );

  modport slave (
    output s_arid, s_araddr, s_arlen, s_arvalid, s_rready,
    output m_axi4_arready, m_axi4_rid, m_axi4_rdata, m_axi4_rresp,
    output m_axi4_rlast, m_axi4_rvalid,
    input  s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
    input  m_axi4_arid, m_axi4_araddr, m_axi4_arlen, m_axi4_arsize,
    input  m_axi4_arburst, m_axi4_arvalid, m_axi4_rready
  );

endinterface

// File: rtl/axi4_read_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req      per-port request flags
//   last     index of the port that was granted most recently
//   grant    first requesting port after 'last', wrapping around
//   any_req  high when at least one port is requesting (grant valid)
module rr_arbiter #(
  parameter  int NUM_PORTS = 2,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic [IDX_W-1:0]     grant,
  output logic                 any_req
);

  logic [IDX_W-1:0] cand;

  // Scan from last+1 upward; the previous winner is visited last, so it
  // only wins again when it is the sole requester.
  always_comb begin
    grant   = last;
    any_req = 1'b0;
    cand    = last;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      cand = IDX_W'((int'(last) + off) % NUM_PORTS);
      if (!any_req && req[cand]) begin
        grant   = cand;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4_read_arbiter.sv
// Shares one AXI4 read master port among NUM_PORTS read requesters.
// Round-robin grant with a single burst in flight: the granted port owns the
// AR channel until its address handshake and the R channel until RLAST.
// Ports:
//   aclk     clock
//   aresetn  synchronous active-low reset
//   bus      axi4_read_arbiter_if.master; interface parameters must match
//            this module's NUM_PORTS / widths
module axi4_read_arbiter
  import axi4_read_arbiter_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_DATA_SIZE  = 2,
  parameter int AXI_DATA_WIDTH = 8 << AXI_DATA_SIZE
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  axi4_read_arbiter_if.master    bus
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] pick;
  logic             any_req;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr (
    .req     (bus.s_arvalid),
    .last    (last_q),
    .grant   (pick),
    .any_req (any_req)
  );

  // last starts at the top index so port 0 is first in line after reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // The round-robin pointer moves only once the address is accepted, so a
  // grant that is still waiting in ADDR does not disturb fairness.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = pick;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (bus.m_axi4_arready) begin
          last_d  = grant_q;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.m_axi4_rvalid && bus.s_rready[grant_q] && bus.m_axi4_rlast) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs. The AR payload is a plain mux of the granted slice;
  // requesters hold it stable until ARREADY so nothing is re-latched. All
  // valids/readies are forced low while reset is asserted, and an RVALID
  // arriving outside the data phase is never forwarded nor accepted.
  always_comb begin
    bus.m_axi4_arvalid = 1'b0;
    bus.m_axi4_rready  = 1'b0;
    bus.s_arready      = '0;
    bus.s_rvalid       = '0;
    bus.m_axi4_arid    = bus.s_arid[grant_q*AXI_ID_WIDTH +: AXI_ID_WIDTH];
    bus.m_axi4_araddr  = bus.s_araddr[grant_q*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
    bus.m_axi4_arlen   = bus.s_arlen[grant_q*AXI_LEN_WIDTH +: AXI_LEN_WIDTH];
    if (aresetn) begin
      case (state_q)
        ST_ADDR: begin
          bus.m_axi4_arvalid     = 1'b1;
          bus.s_arready[grant_q] = bus.m_axi4_arready;
        end
        ST_DATA: begin
          bus.s_rvalid[grant_q] = bus.m_axi4_rvalid;
          bus.m_axi4_rready     = bus.s_rready[grant_q];
        end
        default: ;
      endcase
    end
  end

  assign bus.m_axi4_arsize  = 3'(AXI_DATA_SIZE);
  assign bus.m_axi4_arburst = AXI_BURST_INCR;

  // R payload fans out to every port; only the granted port sees RVALID.
  assign bus.s_rid   = {NUM_PORTS{bus.m_axi4_rid}};
  assign bus.s_rdata = {NUM_PORTS{bus.m_axi4_rdata}};
  assign bus.s_rresp = {NUM_PORTS{bus.m_axi4_rresp}};
  assign bus.s_rlast = {NUM_PORTS{bus.m_axi4_rlast}};

endmodule

// File: tb/tb_axi4_read_arbiter.sv
// Testbench for axi4_read_arbiter: three requesters plus a behavioural AXI4
// slave memory (mem[i] = i, word addressed), with a burst-level reference
// model that predicts grant order and every handshake/beat.
module tb_axi4_read_arbiter;
  import axi4_read_arbiter_pkg::*;

  localparam int NP  = 3;
  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int LW  = 8;
  localparam int DS  = 2;
  localparam int DW  = 8 << DS;
  localparam int IXW = $clog2(NP);

  localparam int M_FREE = 0;
  localparam int M_AR   = 1;
  localparam int M_R    = 2;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;

  always #5 aclk = ~aclk;

  axi4_read_arbiter_if #(
    .NUM_PORTS(NP), .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW),
    .AXI_LEN_WIDTH(LW), .AXI_DATA_WIDTH(DW)
  ) bus ();

  axi4_read_arbiter #(
    .NUM_PORTS(NP), .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW),
    .AXI_LEN_WIDTH(LW), .AXI_DATA_SIZE(DS)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // requesters
  logic          req_v    [NP];
  logic [AW-1:0] req_addr [NP];
  logic [LW-1:0] req_len  [NP];
  logic [IDW-1:0] req_id  [NP];
  logic          rdy      [NP];
  int            repost   [NP];
  bit            allow_rand, rready_rand, toggle_p1, tog, rst_drv;

  // slave memory
  logic           mem_busy;
  logic [AW-1:0]  mem_addr;
  logic [LW-1:0]  mem_len, mem_beat;
  logic [IDW-1:0] mem_id;
  logic           arready_drv, rvalid_drv;
  logic [1:0]     rresp_drv;

  // reference model: who owns the bus and how far its burst has got
  int             ph, mport, mlast, cur_beat;
  logic [AW-1:0]  cur_addr;
  logic [LW-1:0]  cur_len;
  logic [IDW-1:0] cur_id;

  beat_t got_q[$];
  int    grant_log[$];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick();
    for (int k = 1; k <= NP; k++) begin
      int c;
      c = (mlast + k) % NP;
      if (req_v[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit busy_any();
    bit b;
    b = (ph != M_FREE) || mem_busy;
    for (int p = 0; p < NP; p++) b = b || req_v[p];
    return b;
  endfunction

  task automatic post_req(input int p, input logic [AW-1:0] a, input int len);
    req_v[p]    = 1'b1;
    req_addr[p] = a;
    req_len[p]  = LW'(len);
    req_id[p]   = IDW'($urandom);
  endtask

  // Drives requesters and memory just after the falling edge.
  task automatic applyStimulus();
    logic [NP-1:0]     v, rr;
    logic [NP*AW-1:0]  a;
    logic [NP*LW-1:0]  l;
    logic [NP*IDW-1:0] id;
    aresetn = rst_drv;
    tog = !tog;
    for (int p = 0; p < NP; p++) begin
      if (allow_rand && rst_drv && !req_v[p] && $urandom_range(0, 3) == 0)
        post_req(p, AW'($urandom_range(0, 255)) << 2, $urandom_range(0, 4));
      rdy[p] = rready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (toggle_p1 && p == 1) rdy[p] = tog;
      v[IXW'(p)]        = rst_drv && req_v[p];
      rr[IXW'(p)]       = rdy[p];
      a[p*AW +: AW]     = req_addr[p];
      l[p*LW +: LW]     = req_len[p];
      id[p*IDW +: IDW]  = req_id[p];
    end
    bus.s_arvalid = v;
    bus.s_rready  = rr;
    bus.s_araddr  = a;
    bus.s_arlen   = l;
    bus.s_arid    = id;
    arready_drv = !mem_busy && ($urandom_range(0, 2) != 0);
    rvalid_drv  = mem_busy && ($urandom_range(0, 3) != 0);
    rresp_drv   = ($urandom_range(0, 3) == 0) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    bus.m_axi4_arready = arready_drv;
    bus.m_axi4_rvalid  = rvalid_drv;
    bus.m_axi4_rdata   = DW'((mem_addr >> DS) + AW'(mem_beat));
    bus.m_axi4_rlast   = mem_busy && (mem_beat == mem_len);
    bus.m_axi4_rid     = mem_id;
    bus.m_axi4_rresp   = rresp_drv;
  endtask

  // Checks outputs just before the rising edge, then advances the models
  // by the effect of that edge.
  task automatic sampleCheck();
    logic [NP-1:0] exp_ary, exp_rv, exp_last;
    logic          exp_arv, exp_rr;
    logic [DW-1:0] exp_data;
    int            pick;
    exp_arv = aresetn && ph == M_AR;
    exp_ary = '0;
    exp_rv  = '0;
    exp_rr  = 1'b0;
    if (exp_arv) exp_ary[IXW'(mport)] = arready_drv;
    if (aresetn && ph == M_R) begin
      exp_rv[IXW'(mport)] = rvalid_drv;
      exp_rr = rdy[mport];
    end
    checkOutput("m_arvalid", bus.m_axi4_arvalid, exp_arv);
    checkOutput("s_arready", bus.s_arready, exp_ary);
    checkOutput("s_rvalid", bus.s_rvalid, exp_rv);
    checkOutput("m_rready", bus.m_axi4_rready, exp_rr);
    if (exp_arv) begin
      checkOutput("ar_addr", bus.m_axi4_araddr, req_addr[mport]);
      checkOutput("ar_len", bus.m_axi4_arlen, req_len[mport]);
      checkOutput("ar_id", bus.m_axi4_arid, req_id[mport]);
      checkOutput("ar_size", bus.m_axi4_arsize, 3'(DS));
      checkOutput("ar_burst", bus.m_axi4_arburst, 2'b01);
    end
    if (exp_rv != '0) begin
      exp_data = DW'((cur_addr >> DS) + AW'(cur_beat));
      exp_last = (AW'(cur_beat) == AW'(cur_len)) ? '1 : '0;
      for (int p = 0; p < NP; p++)
        checkOutput("r_data", bus.s_rdata[p*DW +: DW], exp_data);
      checkOutput("r_last", bus.s_rlast, exp_last);
      checkOutput("r_resp", bus.s_rresp, {NP{rresp_drv}});
      checkOutput("r_id", bus.s_rid, {NP{cur_id}});
      if (rdy[mport])
        got_q.push_back('{mport, bus.s_rdata[mport*DW +: DW], bus.s_rlast[IXW'(mport)]});
    end
    for (int p = 0; p < NP; p++)
      if (req_v[p] && bus.s_arready[IXW'(p)]) grant_log.push_back(p);

    if (!aresetn) begin
      ph = M_FREE;
      mlast = NP - 1;
      mem_busy = 1'b0;
      for (int p = 0; p < NP; p++) begin
        req_v[p] = 1'b0;
        repost[p] = 0;
      end
      return;
    end

    case (ph)
      M_FREE: begin
        pick = rr_pick();
        if (pick >= 0) begin
          mport = pick;
          ph = M_AR;
        end
      end
      M_AR: begin
        if (arready_drv) begin
          ph = M_R;
          mlast = mport;
          cur_addr = req_addr[mport];
          cur_len = req_len[mport];
          cur_id = req_id[mport];
          cur_beat = 0;
        end
      end
      default: begin
        if (rvalid_drv && rdy[mport]) begin
          if (AW'(cur_beat) == AW'(cur_len)) ph = M_FREE;
          else cur_beat++;
        end
      end
    endcase

    if (!mem_busy && arready_drv && bus.m_axi4_arvalid) begin
      mem_busy = 1'b1;
      mem_addr = bus.m_axi4_araddr;
      mem_len  = bus.m_axi4_arlen;
      mem_id   = bus.m_axi4_arid;
      mem_beat = '0;
    end else if (mem_busy && rvalid_drv && bus.m_axi4_rready) begin
      if (mem_beat == mem_len) mem_busy = 1'b0;
      else mem_beat = mem_beat + 1'b1;
    end

    for (int p = 0; p < NP; p++) begin
      if (req_v[p] && bus.s_arready[IXW'(p)]) begin
        if (repost[p] > 0) begin
          repost[p]--;
          post_req(p, req_addr[p] + 32'h40, int'(req_len[p]));
        end else begin
          req_v[p] = 1'b0;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge aclk);
    applyStimulus();
    #4;
    sampleCheck();
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (busy_any() && n < budget);
    checkOutput("drain", busy_any(), 0);
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      req_v[p] = 1'b0; req_addr[p] = '0; req_len[p] = '0; req_id[p] = '0;
      rdy[p] = 1'b1; repost[p] = 0;
    end
    allow_rand = 0; rready_rand = 0; toggle_p1 = 0; tog = 0; rst_drv = 0;
    mem_busy = 0; mem_addr = '0; mem_len = '0; mem_beat = '0; mem_id = '0;
    ph = M_FREE; mport = 0; mlast = NP - 1; cur_beat = 0;
    cur_addr = '0; cur_len = '0; cur_id = '0;

    // reset state
    repeat (3) cycle();
    rst_drv = 1;
    repeat (2) cycle();

    // two simultaneous requesters: port0 first, then port1
    grant_log.delete(); got_q.delete();
    post_req(0, 32'h0000_0080, 1);
    post_req(1, 32'h0000_0200, 2);
    run_idle(200);
    checkOutput("s2_grants", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      checkOutput("s2_first", grant_log[0], 0);
      checkOutput("s2_second", grant_log[1], 1);
    end
    checkOutput("s2_beats", got_q.size(), 5);
    if (got_q.size() == 5) begin
      checkOutput("s2_p1_data", got_q[2].data, 32'h80);
      checkOutput("s2_p1_port", got_q[4].port, 1);
    end

    // both keep requesting: alternating grants
    grant_log.delete();
    repost[0] = 1; repost[1] = 1;
    post_req(0, 32'h0000_1000, 2);
    post_req(1, 32'h0000_2000, 1);
    run_idle(300);
    checkOutput("s3_grants", grant_log.size(), 4);
    for (int i = 0; i < grant_log.size() && i < 4; i++)
      checkOutput("s3_order", grant_log[i], i % 2);

    // single port burst
    got_q.delete();
    post_req(0, 32'h0000_0100, 3);
    run_idle(200);
    checkOutput("s1_beats", got_q.size(), 4);
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      checkOutput("s1_data", got_q[i].data, 32'h40 + i);
      checkOutput("s1_last", got_q[i].last, i == 3);
      checkOutput("s1_port", got_q[i].port, 0);
    end

    // port1 RREADY alternating through an 8-beat burst
    got_q.delete();
    toggle_p1 = 1;
    post_req(1, 32'h0000_0400, 7);
    run_idle(300);
    toggle_p1 = 0;
    checkOutput("s4_beats", got_q.size(), 8);
    for (int i = 0; i < got_q.size() && i < 8; i++) begin
      checkOutput("s4_data", got_q[i].data, 32'h100 + i);
      checkOutput("s4_last", got_q[i].last, i == 7);
    end

    // arlen=0 from every port
    got_q.delete();
    post_req(0, 32'h0000_0500, 0);
    post_req(1, 32'h0000_0600, 0);
    post_req(2, 32'h0000_0700, 0);
    run_idle(300);
    checkOutput("s5_beats", got_q.size(), 3);
    foreach (got_q[i]) begin
      checkOutput("s5_data", got_q[i].data, 32'h140 + 32'h40 * got_q[i].port);
      checkOutput("s5_last", got_q[i].last, 1);
    end

    // reset in the middle of an 8-beat burst from port1
    post_req(1, 32'h0000_0800, 7);
    begin
      int n;
      n = 0;
      while (!(ph == M_R && cur_beat == 2) && n < 300) begin
        cycle();
        n++;
      end
      checkOutput("s6_reach_beat2", (ph == M_R && cur_beat == 2), 1);
    end
    rst_drv = 0;
    repeat (2) cycle();
    rst_drv = 1;
    repeat (2) cycle();
    grant_log.delete(); got_q.delete();
    post_req(2, 32'h0000_0900, 0);
    post_req(0, 32'h0000_0300, 1);
    run_idle(200);
    checkOutput("s6_grants", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      checkOutput("s6_first", grant_log[0], 0);
      checkOutput("s6_second", grant_log[1], 2);
    end
    if (got_q.size() > 0) checkOutput("s6_data", got_q[0].data, 32'hC0);

    // randomized traffic
    allow_rand = 1; rready_rand = 1;
    repeat (800) cycle();
    allow_rand = 0;
    run_idle(1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
